// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receive front end: pin synchroniser, start-bit detection, mid-bit sampling
// with a runtime bit period, and one-cycle valid / frame-error pulses.
`timescale 1ns/1ps

module uart_rx_deserializer #(
    parameter int unsigned CLK_FREQ     = 25000000,
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned PAYLOAD_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    uart_rxd,
    input  logic                    rx_en_wr_i,
    input  logic                    rx_en_i,
    input  logic                    wr_bit_period_i,
    input  logic [15:0]             bit_period_i,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_busy
);

    localparam int unsigned RESET_PERIOD_INT = CLK_FREQ / BAUD_RATE - 1;
    localparam logic [15:0] RESET_PERIOD     = 16'(RESET_PERIOD_INT);
    localparam logic [15:0] MIN_PERIOD       = 16'd3;
    localparam int          IDX_W            = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    state_e                  state_q, state_d;
    logic                    rxd_meta_q, rxd_s_q;
    logic                    en_q, en_d;
    logic [15:0]             pending_q, pending_d;
    logic [15:0]             active_q, active_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]        bit_idx_q, bit_idx_d;
    logic [PAYLOAD_BITS-1:0] shreg_q, shreg_d;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    frame_err_q, frame_err_d;

    logic        cnt_zero;
    logic        abort;
    logic [15:0] eff_period;

    assign cnt_zero = (cnt_q == 16'd0);
    assign abort    = rx_en_wr_i && !rx_en_i;
    // Tiny periods leave no room for mid-bit sampling, so they are raised to a floor.
    assign eff_period = (pending_q < MIN_PERIOD) ? MIN_PERIOD : pending_q;

    // NOTE: non-blocking assignments for all state so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            en_q        <= 1'b0;
            pending_q   <= RESET_PERIOD;
            active_q    <= RESET_PERIOD;
            cnt_q       <= 16'd0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rxd_meta_q  <= uart_rxd;
            rxd_s_q     <= rxd_meta_q;
            en_q        <= en_d;
            pending_q   <= pending_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // NOTE: every variable is given a default first so no latch can be inferred.
    always_comb begin
        state_d     = state_q;
        en_d        = rx_en_wr_i ? rx_en_i : en_q;
        pending_d   = wr_bit_period_i ? bit_period_i : pending_q;
        active_d    = active_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // A new period only ever takes effect at a frame boundary.
                    if (en_q && !rxd_s_q) begin
                        state_d  = S_START;
                        active_d = eff_period;
                        cnt_d    = eff_period >> 1;
                    end
                end
                S_START: begin
                    if (cnt_zero) begin
                        if (!rxd_s_q) begin
                            state_d   = S_DATA;
                            cnt_d     = active_q;
                            bit_idx_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_zero) begin
                        shreg_d = {rxd_s_q, shreg_q[PAYLOAD_BITS-1:1]};
                        cnt_d   = active_q;
                        if (bit_idx_q == LAST_IDX) begin
                            state_d = S_STOP;
                        end else begin
                            bit_idx_d = bit_idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_zero) begin
                        if (rxd_s_q) begin
                            valid_d = 1'b1;
                            data_d  = shreg_q;
                            state_d = S_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxd_s_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign uart_rx_valid     = valid_q;
    assign uart_rx_data      = data_q;
    assign uart_rx_frame_err = frame_err_q;
    assign uart_rx_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer: frames are driven on the pin and the
// valid / frame-error pulses are recorded by a monitor and compared with hand values.
`timescale 1ns/1ps

module tb_uart_rx_deserializer;

    localparam int BIT_CLKS = 217;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rxd;
    logic        rx_en_wr_i;
    logic        rx_en_i;
    logic        wr_bit_period_i;
    logic [15:0] bit_period_i;
    logic        uart_rx_valid;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_frame_err;
    logic        uart_rx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    int         valid_cnt   = 0;
    int         err_cnt     = 0;
    int         overlap_cnt = 0;
    int         wide_cnt    = 0;
    logic       prev_valid  = 1'b0;
    logic       prev_err    = 1'b0;
    logic [7:0] rx_q[$];

    uart_rx_deserializer #(
        .CLK_FREQ    (25000000),
        .BAUD_RATE   (115200),
        .PAYLOAD_BITS(8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .uart_rxd         (uart_rxd),
        .rx_en_wr_i       (rx_en_wr_i),
        .rx_en_i          (rx_en_i),
        .wr_bit_period_i  (wr_bit_period_i),
        .bit_period_i     (bit_period_i),
        .uart_rx_valid    (uart_rx_valid),
        .uart_rx_data     (uart_rx_data),
        .uart_rx_frame_err(uart_rx_frame_err),
        .uart_rx_busy     (uart_rx_busy)
    );

    always #5 clk = ~clk;

    // Pulses are sampled on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (uart_rx_valid) begin
                valid_cnt <= valid_cnt + 1;
                rx_q.push_back(uart_rx_data);
            end
            if (uart_rx_frame_err) err_cnt <= err_cnt + 1;
            if (uart_rx_valid && uart_rx_frame_err) overlap_cnt <= overlap_cnt + 1;
            if ((uart_rx_valid && prev_valid) || (uart_rx_frame_err && prev_err))
                wide_cnt <= wide_cnt + 1;
        end
        prev_valid <= uart_rx_valid;
        prev_err   <= uart_rx_frame_err;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d, input int clks);
        uart_rxd = 1'b0;
        idle(clks);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = d[i];
            idle(clks);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int clks);
        send_bits(d, clks);
        uart_rxd = 1'b1;
        idle(clks);
    endtask

    task automatic write_en(input logic v);
        rx_en_wr_i = 1'b1;
        rx_en_i    = v;
        @(negedge clk);
        rx_en_wr_i = 1'b0;
    endtask

    task automatic write_period(input logic [15:0] p);
        wr_bit_period_i = 1'b1;
        bit_period_i    = p;
        @(negedge clk);
        wr_bit_period_i = 1'b0;
    endtask

    initial begin
        int base;
        rst_n           = 1'b0;
        uart_rxd        = 1'b1;
        rx_en_wr_i      = 1'b0;
        rx_en_i         = 1'b0;
        wr_bit_period_i = 1'b0;
        bit_period_i    = 16'd0;
        idle(5);
        rst_n = 1'b1;
        idle(2);

        check("reset_busy",  32'(uart_rx_busy),      32'h0);
        check("reset_valid", 32'(uart_rx_valid),     32'h0);
        check("reset_err",   32'(uart_rx_frame_err), 32'h0);
        check("reset_data",  32'(uart_rx_data),      32'h0);

        // Disabled receiver must ignore a long low on the line.
        uart_rxd = 1'b0;
        idle(300);
        check("disabled_busy", 32'(uart_rx_busy), 32'h0);
        uart_rxd = 1'b1;
        idle(10);

        // 1: plain frame
        write_en(1'b1);
        idle(10);
        send_byte(8'hA5, BIT_CLKS);
        idle(20);
        check("t1_valid_cnt", 32'(valid_cnt),    32'd1);
        check("t1_data",      32'(uart_rx_data), 32'hA5);
        check("t1_err_cnt",   32'(err_cnt),      32'd0);
        check("t1_busy",      32'(uart_rx_busy), 32'h0);

        // 2: short glitch is rejected at the mid-start sample
        uart_rxd = 1'b0;
        idle(20);
        check("t2_busy_start", 32'(uart_rx_busy), 32'h1);
        idle(30);
        uart_rxd = 1'b1;
        idle(80);
        check("t2_busy_idle", 32'(uart_rx_busy), 32'h0);
        check("t2_valid_cnt", 32'(valid_cnt),    32'd1);
        check("t2_err_cnt",   32'(err_cnt),      32'd0);

        // 3: stop bit held low for two bit times
        send_bits(8'h3C, BIT_CLKS);
        uart_rxd = 1'b0;
        idle(BIT_CLKS);
        check("t3_err_cnt",   32'(err_cnt),      32'd1);
        check("t3_busy_stop", 32'(uart_rx_busy), 32'h1);
        idle(BIT_CLKS);
        check("t3_busy_wait_high", 32'(uart_rx_busy), 32'h1);
        uart_rxd = 1'b1;
        idle(BIT_CLKS);
        check("t3_busy_idle", 32'(uart_rx_busy), 32'h0);
        check("t3_valid_cnt", 32'(valid_cnt),    32'd1);
        check("t3_data_kept", 32'(uart_rx_data), 32'hA5);
        send_byte(8'h11, BIT_CLKS);
        idle(20);
        check("t3_next_data",  32'(uart_rx_data), 32'h11);
        check("t3_next_valid", 32'(valid_cnt),    32'd2);
        check("t3_next_err",   32'(err_cnt),      32'd1);

        // 4: period change mid-frame only applies to the following frame
        fork
            send_byte(8'h55, BIT_CLKS);
            begin
                idle(500);
                write_period(16'd15);
            end
        join
        idle(20);
        check("t4_old_period_data",  32'(uart_rx_data), 32'h55);
        check("t4_old_period_valid", 32'(valid_cnt),    32'd3);
        send_byte(8'hC3, 16);
        idle(20);
        check("t4_new_period_data",  32'(uart_rx_data), 32'hC3);
        check("t4_new_period_valid", 32'(valid_cnt),    32'd4);

        // Period 0 is raised to 3, i.e. 4 clocks per bit.
        write_period(16'd0);
        idle(5);
        send_byte(8'h96, 4);
        idle(10);
        check("clamp_data",  32'(uart_rx_data), 32'h96);
        check("clamp_valid", 32'(valid_cnt),    32'd5);

        // 5: disable during bit 4 aborts silently
        write_period(16'd216);
        idle(5);
        fork
            send_byte(8'hF0, BIT_CLKS);
            begin
                idle(BIT_CLKS * 5 + 100);
                write_en(1'b0);
                check("t5_abort_busy", 32'(uart_rx_busy), 32'h0);
            end
        join
        idle(20);
        check("t5_valid_cnt", 32'(valid_cnt),    32'd5);
        check("t5_err_cnt",   32'(err_cnt),      32'd1);
        check("t5_data_kept", 32'(uart_rx_data), 32'h96);
        // Enable and period strobes in the same cycle both take effect.
        rx_en_wr_i      = 1'b1;
        rx_en_i         = 1'b1;
        wr_bit_period_i = 1'b1;
        bit_period_i    = 16'd15;
        @(negedge clk);
        rx_en_wr_i      = 1'b0;
        wr_bit_period_i = 1'b0;
        idle(5);
        send_byte(8'h0F, 16);
        idle(20);
        check("t5_reenable_data",  32'(uart_rx_data), 32'h0F);
        check("t5_reenable_valid", 32'(valid_cnt),    32'd6);

        // 6: back-to-back frames with no idle gap
        write_period(16'd216);
        idle(5);
        base = rx_q.size();
        send_byte(8'h00, BIT_CLKS);
        send_byte(8'hFF, BIT_CLKS);
        send_byte(8'h80, BIT_CLKS);
        idle(20);
        check("t6_valid_cnt", 32'(valid_cnt),   32'd9);
        check("t6_q_size",    32'(rx_q.size()), 32'(base + 3));
        if (rx_q.size() >= base + 3) begin
            check("t6_byte0", 32'(rx_q[base]),     32'h00);
            check("t6_byte1", 32'(rx_q[base + 1]), 32'hFF);
            check("t6_byte2", 32'(rx_q[base + 2]), 32'h80);
        end
        check("t6_err_cnt", 32'(err_cnt), 32'd1);

        // Reset in the middle of a frame discards it and clears the output.
        fork
            send_byte(8'h77, BIT_CLKS);
            begin
                idle(600);
                rst_n = 1'b0;
                idle(1);
                rst_n = 1'b1;
                idle(1);
                check("rst_mid_busy", 32'(uart_rx_busy), 32'h0);
                check("rst_mid_data", 32'(uart_rx_data), 32'h0);
            end
        join
        idle(20);
        check("rst_mid_valid_cnt", 32'(valid_cnt), 32'd9);

        check("no_valid_err_overlap", 32'(overlap_cnt), 32'd0);
        check("pulse_width_one",      32'(wide_cnt),    32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
